// File: rtl/vdp_cpu_port.sv
// CPU side of a TMS9918-style VDP: I/O port decode, VRAM access,
// register file R0-R7, status register and interrupt output.
module vdp_cpu_port #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_sel,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic [7:0]        io_din,
  output logic [7:0]        io_dout,
  output logic              io_busy,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_wr,
  output logic              vram_rd,
  output logic [7:0]        vram_din,
  input  logic [7:0]        vram_dout,
  input  logic              frame_int,
  input  logic              sprite_collision,
  input  logic              too_many_sprites,
  input  logic [4:0]        sprite5,
  output logic [1:0]        mode,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       color_table_addr,
  output logic [13:0]       font_addr,
  output logic [13:0]       sprite_attr_addr,
  output logic [13:0]       sprite_pattern_table_addr,
  output logic              video_on,
  output logic              vert_retrace_int,
  output logic              sprite_large,
  output logic              sprite_enlarged,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  output logic              n_int
);

  typedef enum logic [1:0] {IDLE, RD, CAP} state_t;

  state_t            state;
  logic [7:0]        regs [8];
  logic [7:0]        first;
  logic [7:0]        buffer;
  logic              latch_full;
  logic [ADDR_W-1:0] addr;
  logic              f, s5, c;
  logic [4:0]        fifth;

  logic              ctrl_wr, data_wr, stat_rd, data_rd;
  logic [ADDR_W-1:0] new_addr;

  // Strobes only count when idle; a write beats a simultaneous read.
  always_comb begin
    ctrl_wr  = (state == IDLE) & io_wr & io_sel;
    data_wr  = (state == IDLE) & io_wr & ~io_sel;
    stat_rd  = (state == IDLE) & io_rd & ~io_wr & io_sel;
    data_rd  = (state == IDLE) & io_rd & ~io_wr & ~io_sel;
    new_addr = ADDR_W'({io_din[5:0], first});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      first      <= '0;
      buffer     <= '0;
      latch_full <= 1'b0;
      addr       <= '0;
      f          <= 1'b0;
      s5         <= 1'b0;
      c          <= 1'b0;
      fifth      <= '0;
      io_dout    <= '0;
      vram_addr  <= '0;
      vram_wr    <= 1'b0;
      vram_rd    <= 1'b0;
      vram_din   <= '0;
    end else begin
      vram_wr <= 1'b0;
      // Status bits: a set in the read cycle survives the clear.
      f  <= frame_int | (f & ~stat_rd);
      c  <= sprite_collision | (c & ~stat_rd);
      s5 <= too_many_sprites | (s5 & ~stat_rd);
      if (too_many_sprites && (!s5 || stat_rd)) fifth <= sprite5;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            ctrl_wr: begin
              if (!latch_full) begin
                first      <= io_din;
                latch_full <= 1'b1;
              end else begin
                latch_full <= 1'b0;
                if (io_din[7]) regs[io_din[2:0]] <= first;
                else addr <= new_addr;
                if (io_din[7:6] == 2'b00) begin
                  state     <= RD;
                  vram_rd   <= 1'b1;
                  vram_addr <= new_addr;
                end
              end
            end
            data_wr: begin
              vram_wr    <= 1'b1;
              vram_addr  <= addr;
              vram_din   <= io_din;
              buffer     <= io_din;
              addr       <= addr + ADDR_W'(1);
              latch_full <= 1'b0;
            end
            data_rd: begin
              io_dout    <= buffer;
              latch_full <= 1'b0;
              state      <= RD;
              vram_rd    <= 1'b1;
              vram_addr  <= addr;
            end
            stat_rd: begin
              io_dout    <= {f, s5, c, fifth};
              latch_full <= 1'b0;
            end
            default: ;
          endcase
        end
        RD: begin
          vram_rd <= 1'b0;
          state   <= CAP;
        end
        CAP: begin
          buffer <= vram_dout;
          addr   <= addr + ADDR_W'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    if (regs[1][4])      mode = 2'd0;
    else if (regs[0][1]) mode = 2'd2;
    else if (regs[1][3]) mode = 2'd3;
    else                 mode = 2'd1;
    name_table_addr           = {regs[2][3:0], 10'b0};
    color_table_addr          = {regs[3], 6'b0};
    font_addr                 = {regs[4][2:0], 11'b0};
    sprite_attr_addr          = {regs[5][6:0], 7'b0};
    sprite_pattern_table_addr = {regs[6][2:0], 11'b0};
    video_on                  = regs[1][6];
    vert_retrace_int          = regs[1][5];
    sprite_large              = regs[1][1];
    sprite_enlarged           = regs[1][0];
    text_color                = regs[7][7:4];
    back_color                = regs[7][3:0];
    io_busy                   = (state != IDLE);
    n_int                     = ~(f & regs[1][5]);
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Directed bench for vdp_cpu_port with a behavioural VRAM
// (write on vram_wr, registered read data one cycle after vram_rd).
module tb_vdp_cpu_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_sel, io_wr, io_rd;
  logic [7:0]  io_din, io_dout;
  logic        io_busy;
  logic [13:0] vram_addr;
  logic        vram_wr, vram_rd;
  logic [7:0]  vram_din, vram_dout;
  logic        frame_int, sprite_collision, too_many_sprites;
  logic [4:0]  sprite5;
  logic [1:0]  mode;
  logic [13:0] name_table_addr, color_table_addr, font_addr;
  logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
  logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
  logic [3:0]  text_color, back_color;
  logic        n_int;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [16384];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_wr) mem[vram_addr] <= vram_din;
    if (vram_rd) vram_dout <= mem[vram_addr];
  end

  vdp_cpu_port dut (
    .clk(clk), .reset(reset),
    .io_sel(io_sel), .io_wr(io_wr), .io_rd(io_rd),
    .io_din(io_din), .io_dout(io_dout), .io_busy(io_busy),
    .vram_addr(vram_addr), .vram_wr(vram_wr), .vram_rd(vram_rd),
    .vram_din(vram_din), .vram_dout(vram_dout),
    .frame_int(frame_int), .sprite_collision(sprite_collision),
    .too_many_sprites(too_many_sprites), .sprite5(sprite5),
    .mode(mode), .name_table_addr(name_table_addr),
    .color_table_addr(color_table_addr), .font_addr(font_addr),
    .sprite_attr_addr(sprite_attr_addr),
    .sprite_pattern_table_addr(sprite_pattern_table_addr),
    .video_on(video_on), .vert_retrace_int(vert_retrace_int),
    .sprite_large(sprite_large), .sprite_enlarged(sprite_enlarged),
    .text_color(text_color), .back_color(back_color), .n_int(n_int)
  );

  // All bus tasks start and end on a falling edge.
  task automatic do_wr(input logic sel, input logic [7:0] d);
    io_sel = sel; io_din = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic do_rd(input logic sel);
    io_sel = sel; io_rd = 1'b1;
    @(negedge clk);
    io_rd = 1'b0;
  endtask

  task automatic set_reg(input int r, input logic [7:0] v);
    do_wr(1'b1, v);
    do_wr(1'b1, 8'h80 | 8'(r));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (io_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (io_busy) begin
      errors++;
      $display("FAIL wait_idle: io_busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (io_dout !== 8'h00) begin
      errors++; $display("FAIL reset_dout: got %h want 00", io_dout);
    end
    checks++;
    if (mode !== 2'd1) begin
      errors++; $display("FAIL reset_mode: got %0d want 1", mode);
    end
    checks++;
    if ({video_on, n_int, io_busy, vram_wr, vram_rd} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 01000",
               {video_on, n_int, io_busy, vram_wr, vram_rd});
    end
    checks++;
    if ({text_color, back_color} !== 8'h00) begin
      errors++;
      $display("FAIL reset_colors: got %h want 00", {text_color, back_color});
    end
  endtask

  task automatic test_registers();
    set_reg(7, 8'h55);
    checks++;
    if ({text_color, back_color} !== 8'h55) begin
      errors++;
      $display("FAIL r7_colors: got %h want 55", {text_color, back_color});
    end
    set_reg(2, 8'hFF);
    set_reg(3, 8'hFF);
    set_reg(4, 8'hFF);
    set_reg(5, 8'hFF);
    set_reg(6, 8'hFF);
    checks++;
    if ({name_table_addr, color_table_addr, font_addr} !==
        {14'h3C00, 14'h3FC0, 14'h3800}) begin
      errors++;
      $display("FAIL tables_a: got %h %h %h want 3c00 3fc0 3800",
               name_table_addr, color_table_addr, font_addr);
    end
    checks++;
    if ({sprite_attr_addr, sprite_pattern_table_addr} !==
        {14'h3F80, 14'h3800}) begin
      errors++;
      $display("FAIL tables_b: got %h %h want 3f80 3800",
               sprite_attr_addr, sprite_pattern_table_addr);
    end
    set_reg(1, 8'h08);
    checks++;
    if (mode !== 2'd3) begin
      errors++; $display("FAIL mode_multi: got %0d want 3", mode);
    end
    set_reg(0, 8'h02);
    checks++;
    if (mode !== 2'd2) begin
      errors++; $display("FAIL mode_g2: got %0d want 2", mode);
    end
    set_reg(1, 8'h18);
    checks++;
    if (mode !== 2'd0) begin
      errors++; $display("FAIL mode_text: got %0d want 0", mode);
    end
    set_reg(1, 8'h43);
    checks++;
    if ({mode, video_on, vert_retrace_int, sprite_large, sprite_enlarged}
        !== 6'b10_1011) begin
      errors++;
      $display("FAIL r1_bits: got %b want 101011",
               {mode, video_on, vert_retrace_int, sprite_large,
                sprite_enlarged});
    end
    set_reg(0, 8'h00);
    set_reg(1, 8'h00);
  endtask

  task automatic test_data_write();
    do_wr(1'b1, 8'h00);
    do_wr(1'b1, 8'h7F);
    do_wr(1'b0, 8'hAA);
    checks++;
    if ({vram_wr, vram_rd, vram_addr, vram_din} !== {2'b10, 14'h3F00, 8'hAA})
    begin
      errors++;
      $display("FAIL wr_strobe: got wr=%b rd=%b a=%h d=%h want 1 0 3f00 aa",
               vram_wr, vram_rd, vram_addr, vram_din);
    end
    do_wr(1'b0, 8'hBB);
    do_wr(1'b0, 8'hCC);
    checks++;
    if (vram_wr !== 1'b1 || io_busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_busy: got wr=%b busy=%b want 1 0", vram_wr, io_busy);
    end
    @(negedge clk);
    checks++;
    if ({mem[14'h3F00], mem[14'h3F01], mem[14'h3F02]} !== 24'hAABBCC) begin
      errors++;
      $display("FAIL wr_mem: got %h %h %h want aa bb cc",
               mem[14'h3F00], mem[14'h3F01], mem[14'h3F02]);
    end
  endtask

  task automatic test_wrap();
    do_wr(1'b1, 8'hFF);
    do_wr(1'b1, 8'h7F);
    do_wr(1'b0, 8'h11);
    do_wr(1'b0, 8'h22);
    @(negedge clk);
    checks++;
    if ({mem[14'h3FFF], mem[14'h0000]} !== 16'h1122) begin
      errors++;
      $display("FAIL wrap: got %h %h want 11 22",
               mem[14'h3FFF], mem[14'h0000]);
    end
  endtask

  task automatic test_prefetch();
    do_wr(1'b1, 8'h00);
    do_wr(1'b1, 8'h41);
    do_wr(1'b0, 8'h42);
    do_wr(1'b0, 8'h43);
    do_wr(1'b0, 8'h44);
    do_wr(1'b1, 8'h00);
    do_wr(1'b1, 8'h01);
    checks++;
    if ({io_busy, vram_rd, vram_addr} !== {2'b11, 14'h0100}) begin
      errors++;
      $display("FAIL pf_start: got busy=%b rd=%b a=%h want 1 1 0100",
               io_busy, vram_rd, vram_addr);
    end
    wait_idle();
    do_rd(1'b0);
    checks++;
    if (io_dout !== 8'h42) begin
      errors++; $display("FAIL pf_read1: got %h want 42", io_dout);
    end
    wait_idle();
    do_rd(1'b0);
    checks++;
    if (io_dout !== 8'h43) begin
      errors++; $display("FAIL pf_read2: got %h want 43", io_dout);
    end
    checks++;
    if ({vram_rd, vram_addr} !== {1'b1, 14'h0102}) begin
      errors++;
      $display("FAIL pf_addr: got rd=%b a=%h want 1 0102",
               vram_rd, vram_addr);
    end
    wait_idle();
    do_rd(1'b0);
    checks++;
    if (io_dout !== 8'h44) begin
      errors++; $display("FAIL pf_read3: got %h want 44", io_dout);
    end
    wait_idle();
  endtask

  task automatic test_busy_ignore();
    do_rd(1'b0);
    do_wr(1'b1, 8'h33);
    wait_idle();
    set_reg(7, 8'h66);
    checks++;
    if ({text_color, back_color} !== 8'h66) begin
      errors++;
      $display("FAIL busy_ignore: got %h want 66", {text_color, back_color});
    end
  endtask

  task automatic test_interrupt();
    set_reg(1, 8'h20);
    checks++;
    if (n_int !== 1'b1) begin
      errors++; $display("FAIL int_idle: got %b want 1", n_int);
    end
    frame_int = 1'b1;
    @(negedge clk);
    frame_int = 1'b0;
    checks++;
    if (n_int !== 1'b0) begin
      errors++; $display("FAIL int_assert: got %b want 0", n_int);
    end
    do_rd(1'b1);
    checks++;
    if (io_dout[7] !== 1'b1) begin
      errors++; $display("FAIL int_status_f: got %b want 1", io_dout[7]);
    end
    @(negedge clk);
    checks++;
    if (n_int !== 1'b1) begin
      errors++; $display("FAIL int_clear: got %b want 1", n_int);
    end
  endtask

  task automatic test_sprite_status();
    too_many_sprites = 1'b1; sprite5 = 5'h0A;
    @(negedge clk);
    sprite5 = 5'h03;
    @(negedge clk);
    too_many_sprites = 1'b0; sprite_collision = 1'b1;
    @(negedge clk);
    sprite_collision = 1'b0;
    do_rd(1'b1);
    checks++;
    if (io_dout !== 8'h6A) begin
      errors++; $display("FAIL sprite_status: got %h want 6a", io_dout);
    end
    do_rd(1'b1);
    checks++;
    if (io_dout !== 8'h0A) begin
      errors++; $display("FAIL sprite_cleared: got %h want 0a", io_dout);
    end
  endtask

  task automatic test_set_clear();
    frame_int = 1'b1;
    do_rd(1'b1);
    frame_int = 1'b0;
    checks++;
    if (io_dout[7] !== 1'b0) begin
      errors++; $display("FAIL sc_read: got F=%b want 0", io_dout[7]);
    end
    checks++;
    if (n_int !== 1'b0) begin
      errors++; $display("FAIL sc_nint: got %b want 0", n_int);
    end
    do_rd(1'b1);
    checks++;
    if (io_dout !== 8'h8A) begin
      errors++; $display("FAIL sc_status: got %h want 8a", io_dout);
    end
  endtask

  task automatic test_latch_reset();
    do_wr(1'b1, 8'h12);
    do_rd(1'b1);
    set_reg(7, 8'h34);
    checks++;
    if ({text_color, back_color} !== 8'h34) begin
      errors++;
      $display("FAIL latch_clear: got %h want 34", {text_color, back_color});
    end
  endtask

  task automatic test_simultaneous();
    do_wr(1'b1, 8'h00);
    do_wr(1'b1, 8'h42);
    io_rd = 1'b1;
    do_wr(1'b0, 8'h77);
    io_rd = 1'b0;
    checks++;
    if ({io_busy, vram_wr, vram_rd} !== 3'b010) begin
      errors++;
      $display("FAIL simul_flags: got %b want 010",
               {io_busy, vram_wr, vram_rd});
    end
    @(negedge clk);
    checks++;
    if (mem[14'h0200] !== 8'h77) begin
      errors++; $display("FAIL simul_mem: got %h want 77", mem[14'h0200]);
    end
  endtask

  task automatic test_reset_mid_prefetch();
    do_wr(1'b1, 8'h00);
    do_wr(1'b1, 8'h01);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({io_busy, vram_rd} !== 2'b00) begin
      errors++;
      $display("FAIL rst_abort: got busy=%b rd=%b want 0 0", io_busy, vram_rd);
    end
    @(negedge clk);
    checks++;
    if (io_busy !== 1'b0) begin
      errors++; $display("FAIL rst_stay_idle: got %b want 0", io_busy);
    end
    do_rd(1'b0);
    checks++;
    if (io_dout !== 8'h00) begin
      errors++; $display("FAIL rst_buffer: got %h want 00", io_dout);
    end
    wait_idle();
  endtask

  initial begin
    reset = 1'b1;
    io_sel = 1'b0; io_wr = 1'b0; io_rd = 1'b0; io_din = '0;
    frame_int = 1'b0; sprite_collision = 1'b0;
    too_many_sprites = 1'b0; sprite5 = '0;
    @(negedge clk);
    test_reset();
    test_registers();
    test_data_write();
    test_wrap();
    test_prefetch();
    test_busy_ignore();
    test_interrupt();
    test_sprite_status();
    test_set_clear();
    test_latch_reset();
    test_simultaneous();
    test_reset_mid_prefetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
